pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Drives the PC and pipeline-register write enables, and the flush (bubble) controls.
- Causes handled: load-use hazards, taken branches resolved in EX, jumps decoded in ID, and data-memory wait states.
- Also holds a memory-timeout watchdog and saturating stall/flush event counters for debug.

Parameters:
- MEM_TIMEOUT, 64: max consecutive MEM_WAIT cycles before fault; range 1..255.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  input  1  pipeline clock; rising edge.
- reset  input  1  asynchronous, active-high reset.
- id_opcode  input  6  IF/ID instruction [31:26].
- id_rs  input  5  IF/ID instruction [25:21].
- id_rt  input  5  IF/ID instruction [20:16].
- ex_mem_read  input  1  ID/EX MemRead.
- ex_rt  input  5  ID/EX rt (load destination).
- ex_branch_taken  input  1  EX: Branch AND zero.
- dmem_req  input  1  MEM-stage MemRead OR MemWrite.
- dmem_ready  input  1  data memory completes the access this cycle.
- pc_write  output  1  PC load enable.
- ifid_write  output  1  IF/ID register enable.
- ifid_flush  output  1  IF/ID loads NOP next edge.
- idex_flush  output  1  ID/EX control bits cleared next edge.
- exmem_write  output  1  EX/MEM register enable.
- memwb_write  output  1  MEM/WB register enable.
- mem_error  output  1  sticky timeout fault.
- stall_cycles  output  CNT_W  saturating count of load-use plus MEM_WAIT cycles.
- flush_events  output  CNT_W  saturating count of branch and jump flushes.

Behaviour:
- State register (RUN, MEM_WAIT, HALT) plus 8-bit wait_cnt.
  - All are cleared asynchronously on reset: state=RUN, wait_cnt=0, mem_error=0, both counters 0.
- While reset is high: all *_write=0, ifid_flush=1, idex_flush=1.
- Control outputs are combinational from state and inputs, so stalls apply in the same cycle as detection. They change state only on the clk edge.
- Defaults in RUN with no hazard: all *_write=1, flushes=0.
- RUN priority, highest first:
  1. Mem wait: dmem_req=1 and dmem_ready=0.
     - All *_write=0, flushes=0.
     - Next state = MEM_WAIT, wait_cnt <= 1, stall_cycles++.
     - This cycle counts as one wait cycle.
  2. Branch taken: ex_branch_taken=1.
     - pc_write=1, ifid_flush=1, idex_flush=1.
     - flush_events++.
     - Load-use and jump are ignored this cycle, since the younger instructions are discarded.
  3. Load-use: ex_mem_read=1, ex_rt!=0, and either ex_rt==id_rs, or ex_rt==id_rt with id_opcode in {000000, 101011, 000100}.
     - pc_write=0, ifid_write=0, idex_flush=1.
     - stall_cycles++.
     - Exactly one bubble; the condition clears naturally next cycle.
  4. Jump: id_opcode==000010.
     - ifid_flush=1, flush_events++.
- MEM_WAIT:
  - All *_write=0, flushes=0. ex_branch_taken, load-use and jump are ignored, because the frozen EX/ID state is re-evaluated on return to RUN.
  - If dmem_ready=1: this cycle has the RUN-default enables (the access completes), next state = RUN, wait_cnt <= 0.
  - Else if wait_cnt==MEM_TIMEOUT: mem_error <= 1, next state = HALT.
  - Else: wait_cnt++, stall_cycles++.
  - A dmem_req drop without ready is treated as ready (abort): return to RUN.
- HALT:
  - All *_write=0, flushes=0, mem_error=1.
  - Counters frozen. Left only via reset.
- Counters saturate at all-ones and never wrap. Each increments at most once per cycle.
- Reset mid-MEM_WAIT or in HALT: state returns to RUN immediately (asynchronously), mem_error clears.

Test Plan:
- lw $2 in EX (ex_mem_read=1, ex_rt=2), add with id_rs=2 in ID -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cycles=1; next cycle defaults.
- Load-use plus register-0 / rt-unused checks:
  - ex_rt=0 with id_rs=0 -> no stall.
  - ex_rt=5, id_rt=5, id_opcode=100011 (lw, rt not a source) -> no stall.
  - same with id_opcode=000000 -> stall.
- ex_branch_taken=1 together with a load-use match -> ifid_flush=1, idex_flush=1, pc_write=1, flush_events=1, stall_cycles unchanged.
- jump opcode 000010 in ID -> ifid_flush=1 for one cycle, pc_write=1, flush_events increments.
- dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> all enables 0 for 3 cycles, enables 1 on the 4th, stall_cycles=3, state RUN.
- MEM_TIMEOUT=4, dmem_ready held 0:
  - mem_error=1 after 5 cycles, enables stay 0 indefinitely.
  - asserting reset mid-HALT clears mem_error and counters asynchronously; counter saturation is checked with CNT_W=2 (stops at 3).

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline: load-use, branch, jump and
// data-memory wait handling, plus a memory-timeout watchdog and debug counters.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [1:0]       fsm_state
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] HALT     = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  logic [1:0] state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       set_error;
  logic       stall_inc;
  logic       flush_inc;
  logic       rt_is_source;
  logic       load_use;
  logic       mem_stuck;

  // rt is only read as a source by R-type, sw and beq.
  assign rt_is_source = (id_opcode == OP_RTYPE) || (id_opcode == OP_SW) || (id_opcode == OP_BEQ);
  assign load_use     = ex_mem_read && (ex_rt != 5'd0) &&
                        ((ex_rt == id_rs) || ((ex_rt == id_rt) && rt_is_source));
  assign mem_stuck    = dmem_req && !dmem_ready;
  assign fsm_state    = state;

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    exmem_write  = 1'b1;
    memwb_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    set_error    = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    case (state)
      RUN: begin
        if (mem_stuck) begin
          {pc_write, ifid_write, exmem_write, memwb_write} = 4'b0000;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
          stall_inc    = 1'b1;
        end else if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          flush_inc  = 1'b1;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
        end else if (id_opcode == OP_J) begin
          ifid_flush = 1'b1;
          flush_inc  = 1'b1;
        end
      end
      MEM_WAIT: begin
        // A dropped request is an abort and completes like a ready access.
        if (!mem_stuck) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end else begin
          {pc_write, ifid_write, exmem_write, memwb_write} = 4'b0000;
          if (wait_cnt == TIMEOUT_CNT) begin
            set_error = 1'b1;
            state_nxt = HALT;
          end else begin
            wait_cnt_nxt = wait_cnt + 8'd1;
            stall_inc    = 1'b1;
          end
        end
      end
      default: begin
        {pc_write, ifid_write, exmem_write, memwb_write} = 4'b0000;
        state_nxt = HALT;
      end
    endcase
    if (reset) begin
      {pc_write, ifid_write, exmem_write, memwb_write} = 4'b0000;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      wait_cnt     <= 8'd0;
      mem_error    <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_error <= mem_error | set_error;
      if (stall_inc && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_inc && (flush_events != {CNT_W{1'b1}}))
        flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios plus random traffic
// against a cycle-level reference model; a narrow-counter copy checks saturation.
module tb_pipeline_hazard_controller;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] id_opcode = '0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;

  logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_write, mem_error;
  logic [15:0] stall_cycles, flush_events;
  logic [1:0]  fsm_state;
  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_exmem_write, s_memwb_write;
  logic        s_mem_error;
  logic [1:0]  s_stall_cycles, s_flush_events, s_fsm_state;

  pipeline_hazard_controller #(.MEM_TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_write(exmem_write), .memwb_write(memwb_write), .mem_error(mem_error),
    .stall_cycles(stall_cycles), .flush_events(flush_events), .fsm_state(fsm_state)
  );

  pipeline_hazard_controller #(.MEM_TIMEOUT(TMO), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_write(s_pc_write),
    .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .exmem_write(s_exmem_write), .memwb_write(s_memwb_write), .mem_error(s_mem_error),
    .stall_cycles(s_stall_cycles), .flush_events(s_flush_events), .fsm_state(s_fsm_state)
  );

  always #5 clk = ~clk;

  wire [5:0] ctrl = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_write};

  int checks = 0;
  int errors = 0;

  // Reference model: pipeline mode flags, length of the current memory wait, event totals.
  bit m_waiting, m_halted, m_err;
  int m_wait_len, m_stalls, m_flushes;

  function automatic int sat(input int v, input int w);
    int lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  function automatic bit lu_hazard();
    bit rt_src = (id_opcode == 6'h00) || (id_opcode == 6'h2b) || (id_opcode == 6'h04);
    return ex_mem_read && (ex_rt != 0) && ((ex_rt == id_rs) || ((ex_rt == id_rt) && rt_src));
  endfunction

  // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_write}
  function automatic logic [5:0] exp_ctrl();
    bit stuck = dmem_req && !dmem_ready;
    if (reset)             return 6'b001100;
    if (m_halted)          return 6'b000000;
    if (m_waiting)         return stuck ? 6'b000000 : 6'b110011;
    if (stuck)             return 6'b000000;
    if (ex_branch_taken)   return 6'b111111;
    if (lu_hazard())       return 6'b000111;
    if (id_opcode == 6'h02) return 6'b111011;
    return 6'b110011;
  endfunction

  function automatic logic [32:0] exp_stat();
    return {16'(sat(m_stalls, 16)), 16'(sat(m_flushes, 16)), m_err};
  endfunction

  function automatic logic [4:0] exp_sat();
    return {2'(sat(m_stalls, 2)), 2'(sat(m_flushes, 2)), m_err};
  endfunction

  task automatic model_reset();
    m_waiting = 0; m_halted = 0; m_err = 0;
    m_wait_len = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_step();
    bit stuck = dmem_req && !dmem_ready;
    if (m_halted) return;
    if (m_waiting) begin
      if (!stuck) m_waiting = 0;
      else if (m_wait_len == TMO) begin m_halted = 1; m_err = 1; m_waiting = 0; end
      else begin m_wait_len++; m_stalls++; end
    end else if (stuck) begin
      m_waiting = 1; m_wait_len = 1; m_stalls++;
    end else if (ex_branch_taken) m_flushes++;
    else if (lu_hazard()) m_stalls++;
    else if (id_opcode == 6'h02) m_flushes++;
  endtask

  task automatic set_in(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic mr, input logic [4:0] xrt, input logic br,
                        input logic req, input logic rdy);
    id_opcode = op; id_rs = rs; id_rt = rt; ex_mem_read = mr; ex_rt = xrt;
    ex_branch_taken = br; dmem_req = req; dmem_ready = rdy;
  endtask

  // Clock edge; model follows the same inputs; land 1ns after the edge.
  task automatic cycle();
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++;
    if (ctrl !== 6'b001100) begin errors++; $display("FAIL reset_ctrl got %b want %b", ctrl, 6'b001100); end
    checks++;
    if ({stall_cycles, flush_events, mem_error} !== 33'd0) begin
      errors++; $display("FAIL reset_stat got %h want 0", {stall_cycles, flush_events, mem_error});
    end
    checks++;
    if ({s_stall_cycles, s_flush_events, s_mem_error} !== 5'd0) begin
      errors++; $display("FAIL reset_sat got %b want 0", {s_stall_cycles, s_flush_events, s_mem_error});
    end
    cycle(); cycle();
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    logic [26:0] tbl [8];
    // {opcode, rs, rt, ex_mem_read, ex_rt, pad}
    tbl[0] = {6'h00, 5'd2, 5'd7, 1'b1, 5'd2, 5'd0};  // lw $2 ; add uses $2 as rs
    tbl[1] = {6'h00, 5'd2, 5'd7, 1'b0, 5'd2, 5'd0};  // load has moved on
    tbl[2] = {6'h00, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0};  // $0 never hazards
    tbl[3] = {6'h23, 5'd1, 5'd5, 1'b1, 5'd5, 5'd0};  // lw: rt is a destination
    tbl[4] = {6'h00, 5'd1, 5'd5, 1'b1, 5'd5, 5'd0};  // R-type reads rt
    tbl[5] = {6'h2b, 5'd1, 5'd5, 1'b1, 5'd5, 5'd0};  // sw reads rt
    tbl[6] = {6'h04, 5'd1, 5'd5, 1'b1, 5'd5, 5'd0};  // beq reads rt
    tbl[7] = {6'h08, 5'd1, 5'd5, 1'b1, 5'd5, 5'd0};  // addi: rt unused as source
    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i][26:21], tbl[i][20:16], tbl[i][15:11], tbl[i][10], tbl[i][9:5], 1'b0, 1'b0, 1'b0);
      #2;
      checks++;
      if (ctrl !== exp_ctrl()) begin errors++; $display("FAIL load_use_ctrl[%0d] got %b want %b", i, ctrl, exp_ctrl()); end
      cycle();
      checks++;
      if ({stall_cycles, flush_events, mem_error} !== exp_stat()) begin
        errors++; $display("FAIL load_use_stat[%0d] got %h want %h", i, {stall_cycles, flush_events, mem_error}, exp_stat());
      end
    end
  endtask

  task automatic test_branch();
    set_in(6'h00, 5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);  // branch beats load-use
    #2;
    checks++;
    if (ctrl !== exp_ctrl()) begin errors++; $display("FAIL branch_lu_ctrl got %b want %b", ctrl, exp_ctrl()); end
    cycle();
    set_in(6'h02, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);  // branch with jump: one flush event
    #2;
    checks++;
    if (ctrl !== exp_ctrl()) begin errors++; $display("FAIL branch_jump_ctrl got %b want %b", ctrl, exp_ctrl()); end
    cycle();
    set_in(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    checks++;
    if ({stall_cycles, flush_events, mem_error} !== exp_stat()) begin
      errors++; $display("FAIL branch_stat got %h want %h", {stall_cycles, flush_events, mem_error}, exp_stat());
    end
  endtask

  task automatic test_jump();
    set_in(6'h02, 5'd4, 5'd4, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0);
    #2;
    checks++;
    if (ctrl !== 6'b111011) begin errors++; $display("FAIL jump_ctrl got %b want %b", ctrl, 6'b111011); end
    cycle();
    set_in(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    checks++;
    if (ctrl !== 6'b110011) begin errors++; $display("FAIL jump_after_ctrl got %b want %b", ctrl, 6'b110011); end
    checks++;
    if ({stall_cycles, flush_events, mem_error} !== exp_stat()) begin
      errors++; $display("FAIL jump_stat got %h want %h", {stall_cycles, flush_events, mem_error}, exp_stat());
    end
  endtask

  task automatic test_mem_wait();
    int s0 = m_stalls;
    for (int i = 0; i < 5; i++) begin
      // three not-ready cycles (with a hazard that must be ignored), then ready, then idle
      set_in(6'h02, 5'd6, 5'd0, 1'b1, 5'd6, 1'b1, i < 4, i == 3);
      #2;
      checks++;
      if (ctrl !== exp_ctrl()) begin errors++; $display("FAIL mem_wait_ctrl[%0d] got %b want %b", i, ctrl, exp_ctrl()); end
      if (i == 3) begin
        checks++;
        if (stall_cycles !== 16'(s0 + 3)) begin
          errors++; $display("FAIL mem_wait_stalls got %0d want %0d", stall_cycles, s0 + 3);
        end
      end
      cycle();
    end
    set_in(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    set_in(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #2;
      checks++;
      if (ctrl !== 6'b000000) begin errors++; $display("FAIL timeout_ctrl[%0d] got %b want 000000", i, ctrl); end
      checks++;
      if (mem_error !== (i >= TMO + 1)) begin
        errors++; $display("FAIL timeout_err[%0d] got %b want %b", i, mem_error, i >= TMO + 1);
      end
      cycle();
    end
    checks++;
    if ({stall_cycles, flush_events, mem_error} !== exp_stat()) begin
      errors++; $display("FAIL timeout_stat got %h want %h", {stall_cycles, flush_events, mem_error}, exp_stat());
    end
    #2;
    reset = 1'b1;  // asynchronous, mid-cycle, while halted
    model_reset();
    #1;
    checks++;
    if ({stall_cycles, flush_events, mem_error, s_mem_error} !== 34'd0) begin
      errors++; $display("FAIL halt_reset got %h want 0", {stall_cycles, flush_events, mem_error, s_mem_error});
    end
    checks++;
    if (ctrl !== 6'b001100) begin errors++; $display("FAIL halt_reset_ctrl got %b want 001100", ctrl); end
    cycle();
    reset = 1'b0;
    set_in(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    checks++;
    if (ctrl !== 6'b110011) begin errors++; $display("FAIL after_reset_ctrl got %b want 110011", ctrl); end
    cycle();
  endtask

  task automatic test_saturation();
    set_in(6'h00, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle();
    set_in(6'h02, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    #2;
    checks++;
    if ({s_stall_cycles, s_flush_events} !== 4'b1111) begin
      errors++; $display("FAIL sat_counters got %b want 1111", {s_stall_cycles, s_flush_events});
    end
    checks++;
    if ({stall_cycles, flush_events, mem_error} !== exp_stat()) begin
      errors++; $display("FAIL sat_wide got %h want %h", {stall_cycles, flush_events, mem_error}, exp_stat());
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    int stuck = 0;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2b; ops[3] = 6'h04; ops[4] = 6'h02; ops[5] = 6'h08;
    for (int i = 0; i < 600; i++) begin
      logic req, rdy;
      if (stuck == 0 && $urandom_range(0, 59) == 0) stuck = 7;
      req = (stuck > 0) || ($urandom_range(0, 2) == 0);
      rdy = (stuck > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (stuck > 0) stuck--;
      set_in(ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom_range(0, 5) == 0, req, rdy);
      reset = m_halted && ($urandom_range(0, 4) == 0);
      if (reset) model_reset();
      #2;
      checks++;
      if (ctrl !== exp_ctrl()) begin errors++; $display("FAIL rand_ctrl[%0d] got %b want %b", i, ctrl, exp_ctrl()); end
      checks++;
      if ({stall_cycles, flush_events, mem_error} !== exp_stat()) begin
        errors++; $display("FAIL rand_stat[%0d] got %h want %h", i, {stall_cycles, flush_events, mem_error}, exp_stat());
      end
      checks++;
      if ({s_stall_cycles, s_flush_events, s_mem_error} !== exp_sat()) begin
        errors++; $display("FAIL rand_sat[%0d] got %b want %b", i, {s_stall_cycles, s_flush_events, s_mem_error}, exp_sat());
      end
      cycle();
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_jump();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
